// File: rtl/pattern_test_ctrl_pkg.sv
// Shared definitions for the pattern test controller and its generator:
// pattern length, expected patterns, FSM state encoding and index search.
package pattern_test_ctrl_pkg;

    localparam int PTC_N = 4;

    localparam logic [PTC_N-1:0] PTC_PAT0 = 4'b1010;
    localparam logic [PTC_N-1:0] PTC_PAT1 = 4'b0101;
    localparam logic [PTC_N-1:0] PTC_PAT2 = 4'b1100;
    localparam logic [PTC_N-1:0] PTC_PAT3 = 4'b0011;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } nextIdx_t;

    // Lowest enabled index at or above 'from'; a 'from' of 4 never matches,
    // so the search cannot wrap back to index 0.
    function automatic nextIdx_t findNext(input logic [3:0] mask, input logic [2:0] from);
        nextIdx_t res;
        res = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res.found = 1'b1;
                res.idx   = i[1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pattern_test_ctrl_if.sv
// Run-control and generator handshake signals of the pattern test controller.
interface pattern_test_ctrl_if;

    logic       start;
    logic [3:0] mask;
    logic       s_in;
    logic       seq_d_in;
    logic [1:0] gen_add;
    logic       gen_rst;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_vec;

    modport master (
        output start, mask, s_in, seq_d_in,
        input  gen_add, gen_rst, busy, done, pass, err_vec
    );

    modport slave (
        input  start, mask, s_in, seq_d_in,
        output gen_add, gen_rst, busy, done, pass, err_vec
    );

endinterface

// File: rtl/pattern_test_ctrl_capture.sv
// Serial capture of one generator pattern: LSB-first shift register,
// bit counter and sticky protocol-fault flag on the sequence-done line.
module pattern_capture
    import pattern_test_ctrl_pkg::*;
#(
    parameter int N = PTC_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_shiftEn,
    input  logic         i_sIn,
    input  logic         i_seqDone,
    output logic [N-1:0] o_cap,
    output logic         o_lastBit,
    output logic         o_fault
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  r_cap;
    logic [KW-1:0] r_bitCnt;
    logic          r_fault;
    logic          w_lastBit;
    logic          w_faultNow;

    assign w_lastBit  = (r_bitCnt == KW'(N - 1));
    // seq_d_in must be low on every bit except the last, where it must be high
    assign w_faultNow = w_lastBit ? ~i_seqDone : i_seqDone;

    // Capture bit k into cap[k], count bits and latch any protocol fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cap    <= '0;
            r_bitCnt <= '0;
            r_fault  <= 1'b0;
        end else if (i_clear) begin
            r_cap    <= '0;
            r_bitCnt <= '0;
            r_fault  <= 1'b0;
        end else if (i_shiftEn) begin
            r_cap[r_bitCnt] <= i_sIn;
            r_bitCnt        <= w_lastBit ? '0 : r_bitCnt + KW'(1);
            if (w_faultNow) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign o_cap     = r_cap;
    assign o_lastBit = w_lastBit;
    assign o_fault   = r_fault;

endmodule

// File: rtl/pattern_test_ctrl.sv
// Pattern test controller: walks the enabled generator addresses in
// ascending order, restarts the generator, captures and checks each pattern.
module pattern_test_ctrl
    import pattern_test_ctrl_pkg::*;
#(
    parameter int           N    = PTC_N,
    parameter logic [N-1:0] PAT0 = PTC_PAT0,
    parameter logic [N-1:0] PAT1 = PTC_PAT1,
    parameter logic [N-1:0] PAT2 = PTC_PAT2,
    parameter logic [N-1:0] PAT3 = PTC_PAT3
) (
    input logic               clk,
    input logic               rst,
    pattern_test_ctrl_if.slave bus
);

    logic [2:0]   r_state;
    logic [3:0]   r_mask;
    logic [1:0]   r_idx;
    logic [3:0]   r_errVec;
    logic         r_pass;
    logic         r_done;

    logic [2:0]   w_nextState;
    logic         w_accept;
    nextIdx_t     w_first;
    nextIdx_t     w_next;
    logic [N-1:0] w_cap;
    logic [N-1:0] w_expected;
    logic         w_lastBit;
    logic         w_fault;
    logic         w_capErr;

    // A start landing in the done-pulse cycle is refused so one request
    // never produces two back-to-back runs.
    assign w_accept = (r_state == ST_IDLE) && bus.start && !r_done;
    assign w_first  = findNext(bus.mask, 3'd0);
    assign w_next   = findNext(r_mask, {1'b0, r_idx} + 3'd1);

    pattern_capture #(.N(N)) u_capture (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ST_LOAD),
        .i_shiftEn (r_state == ST_SHIFT),
        .i_sIn     (bus.s_in),
        .i_seqDone (bus.seq_d_in),
        .o_cap     (w_cap),
        .o_lastBit (w_lastBit),
        .o_fault   (w_fault)
    );

    // Select the reference pattern for the address currently under test
    always_comb begin
        w_expected = PAT3;
        case (r_idx)
            2'd0:    w_expected = PAT0;
            2'd1:    w_expected = PAT1;
            2'd2:    w_expected = PAT2;
            default: w_expected = PAT3;
        endcase
    end

    assign w_capErr = (w_cap != w_expected) || w_fault;

    // Next-state logic of the run sequencer
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_nextState = w_first.found ? ST_LOAD : ST_DONE;
            ST_LOAD:  w_nextState = ST_WAIT;
            ST_WAIT:  w_nextState = ST_SHIFT;
            ST_SHIFT: if (w_lastBit) w_nextState = ST_CHECK;
            ST_CHECK: w_nextState = w_next.found ? ST_LOAD : ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // State, address, error vector and result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_mask   <= '0;
            r_idx    <= '0;
            r_errVec <= '0;
            r_pass   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_mask   <= bus.mask;
                        r_errVec <= '0;
                        r_pass   <= 1'b0;
                        if (w_first.found) begin
                            r_idx <= w_first.idx;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_capErr) begin
                        r_errVec[r_idx] <= 1'b1;
                    end
                    if (w_next.found) begin
                        r_idx <= w_next.idx;
                    end
                end
                ST_DONE: r_pass <= (r_errVec == '0);
                default: ;
            endcase
        end
    end

    assign bus.gen_add = r_idx;
    assign bus.gen_rst = (r_state == ST_LOAD);
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_vec = r_errVec;

endmodule

// File: tb/tb_pattern_test_ctrl.sv
// Self-checking bench for pattern_test_ctrl with a golden pattern generator
// and fault injection; expectations come from a run-level reference model.
module tb_pattern_test_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int testsRun    = 0;
    int testsFailed = 0;

    int   genCnt    = 0;
    logic genActive = 1'b0;
    logic [3:0] genPat;
    logic genSIn;
    logic genSeq;

    // 0 none, 1 flip bit injK, 2 force s_in high, 3 seq_d high at injK, 4 seq_d low at last bit
    int injKind = 0;
    int injAddr = 0;
    int injK    = 0;

    pattern_test_ctrl_if bus ();

    pattern_test_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [3:0] refPat(input logic [1:0] a);
        case (a)
            2'd0:    return 4'b1010;
            2'd1:    return 4'b0101;
            2'd2:    return 4'b1100;
            default: return 4'b0011;
        endcase
    endfunction

    // Golden generator sequencing: restart on gen_rst, idle one cycle, then stream bits
    always @(posedge clk) begin
        if (bus.gen_rst) begin
            genActive <= 1'b0;
            genCnt    <= 0;
        end else if (!genActive) begin
            genActive <= 1'b1;
            genCnt    <= 0;
        end else begin
            genCnt <= genCnt + 1;
        end
    end

    // Generator outputs with optional fault injection on the selected address
    always_comb begin
        genPat = refPat(bus.gen_add);
        genSIn = 1'b0;
        genSeq = 1'b0;
        if (genActive && genCnt < 4) begin
            genSIn = genPat[genCnt[1:0]];
            genSeq = (genCnt == 3);
            if (int'(bus.gen_add) == injAddr) begin
                if (injKind == 1 && genCnt == injK) genSIn = ~genSIn;
                if (injKind == 2) genSIn = 1'b1;
                if (injKind == 3 && genCnt == injK) genSeq = 1'b1;
                if (injKind == 4 && genCnt == 3) genSeq = 1'b0;
            end
        end
    end

    assign bus.s_in     = genSIn;
    assign bus.seq_d_in = genSeq;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},   32'(bus.busy),    0);
        checkOutput({tag, "_done"},   32'(bus.done),    0);
        checkOutput({tag, "_pass"},   32'(bus.pass),    0);
        checkOutput({tag, "_err"},    32'(bus.err_vec), 0);
        checkOutput({tag, "_genAdd"}, 32'(bus.gen_add), 0);
        checkOutput({tag, "_genRst"}, 32'(bus.gen_rst), 0);
    endtask

    // One complete run: start, observe every cycle, compare with the reference model
    task automatic applyStimulus(input logic [3:0] m, input int kind, input int addr,
                                 input int k, input bit disturb);
        int         expCount;
        logic [3:0] expErr;
        int         expAdds[$];
        int         gotAdds[$];
        int         c;
        int         doneAt;
        int         doneCount;
        int         limit;
        expCount = 0;
        expErr   = '0;
        expAdds  = {};
        gotAdds  = {};
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                expCount++;
                expAdds.push_back(i);
            end
        end
        if (kind != 0 && m[addr]) expErr[addr] = 1'b1;
        injKind = kind;
        injAddr = addr;
        injK    = k;
        limit   = 7 * expCount + 12;

        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = m;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        if (disturb) bus.mask = ~m;
        checkOutput("clearErr",  32'(bus.err_vec), 0);
        checkOutput("clearPass", 32'(bus.pass),    0);
        checkOutput("busyAtRun", 32'(bus.busy),    1);
        if (bus.gen_rst) gotAdds.push_back(int'(bus.gen_add));
        c         = 0;
        doneAt    = -1;
        doneCount = 0;
        while (c < limit) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.gen_rst) gotAdds.push_back(int'(bus.gen_add));
            if (bus.done) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = c;
                    checkOutput("passAtDone", 32'(bus.pass),    32'(expErr == 4'h0));
                    checkOutput("errAtDone",  32'(bus.err_vec), 32'(expErr));
                    checkOutput("busyAtDone", 32'(bus.busy),    0);
                    if (disturb) bus.start = 1'b1;
                end
            end
            if (disturb && c == 3 && expCount > 0) bus.start = 1'b1;
        end
        bus.start = 1'b0;
        checkOutput("doneCycle", 32'(doneAt),    32'(7 * expCount + 1));
        checkOutput("doneCount", 32'(doneCount), 1);
        checkOutput("genAddCount", 32'(gotAdds.size()), 32'(expAdds.size()));
        for (int i = 0; i < expAdds.size(); i++) begin
            if (i < gotAdds.size()) checkOutput("genAddSeq", 32'(gotAdds[i]), 32'(expAdds[i]));
        end
        checkOutput("errHeld",  32'(bus.err_vec), 32'(expErr));
        checkOutput("passHeld", 32'(bus.pass),    32'(expErr == 4'h0));
        injKind = 0;
    endtask

    // Abort a 4'b0011 run during the SHIFT phase of pattern 1
    task automatic applyMidRunReset();
        int doneCount;
        injKind = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mask  = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("preResetGenAdd", 32'(bus.gen_add), 1);
        checkOutput("preResetBusy",   32'(bus.busy),    1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("midReset");
        rst = 1'b1;
        doneCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("abortedDone", 32'(doneCount), 0);
    endtask

    // Directed scenarios followed by randomized runs
    initial begin
        logic [3:0] rMask;
        int         rKind;
        int         rAddr;
        int         rK;
        bit         rDist;
        bus.start = 1'b0;
        bus.mask  = 4'h0;
        rst       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] full mask run");
        applyStimulus(4'hF, 0, 0, 0, 1'b0);
        $display("[TB] mask 0101 with s_in forced on pattern 2");
        applyStimulus(4'b0101, 2, 2, 0, 1'b0);
        $display("[TB] empty mask run");
        applyStimulus(4'h0, 0, 0, 0, 1'b0);
        $display("[TB] early seq_d_in on pattern 0");
        applyStimulus(4'b0001, 3, 0, 1, 1'b0);
        $display("[TB] reset during pattern 1 shift");
        applyMidRunReset();
        applyStimulus(4'b0011, 0, 0, 0, 1'b0);
        $display("[TB] start pulses while busy and at done");
        applyStimulus(4'hF, 0, 0, 0, 1'b1);
        applyStimulus(4'h0, 0, 0, 0, 1'b1);

        $display("[TB] randomized runs");
        for (int t = 0; t < 14; t++) begin
            rMask = 4'($urandom_range(0, 15));
            rKind = int'($urandom_range(0, 4));
            rAddr = int'($urandom_range(0, 3));
            rK    = (rKind == 3) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
            rDist = 1'($urandom_range(0, 1));
            applyStimulus(rMask, rKind, rAddr, rK, rDist);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
